// File: rtl/rtc_pkg.sv
// Shared encodings, BCD limits and calendar helpers for the RTC digit bank.
// All calendar values are packed BCD bytes {tens, units}.
package rtc_pkg;

  typedef enum logic [2:0] {
    FLD_SEC   = 3'd0,
    FLD_MIN   = 3'd1,
    FLD_HOUR  = 3'd2,
    FLD_DAY   = 3'd3,
    FLD_MONTH = 3'd4,
    FLD_YEAR  = 3'd5
  } rtc_field_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_99 = 8'h99;

  // Non-leap month lengths, January first.
  localparam logic [7:0] MONTH_LEN [12] = '{
    8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
    8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
  };

  // Full register set, also used as the frame-coherent shadow image.
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] day;
    logic [7:0] month;
    logic [7:0] year;
    logic [7:0] chour;
    logic [7:0] cmin;
    logic [7:0] csec;
  } rtc_set_t;

  // A BCD year is a multiple of 4 when: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
  function automatic logic is_leap(input logic [7:0] yy);
    if (yy[4])
      return (yy[3:0] == 4'd2) || (yy[3:0] == 4'd6);
    return (yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] mm, input logic [7:0] yy);
    logic [3:0] idx;
    idx = (mm[7:4] != 4'd0) ? (mm[3:0] + 4'd9) : (mm[3:0] - 4'd1);
    if (idx > 4'd11)
      return 8'h31;
    if (idx == 4'd1 && is_leap(yy))
      return 8'h29;
    return MONTH_LEN[idx];
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter: load beats increment; at the wrap limit an increment
// returns to the minimum value and raises carry in the same cycle.
module bcd2_counter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max_val,
  input  logic [7:0] min_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_reg;
  logic [7:0] value_next;
  logic       at_max;

  assign at_max = (value_reg == max_val);
  assign carry  = inc & at_max;
  assign value  = value_reg;

  always_comb begin
    value_next = value_reg;
    if (value_reg[3:0] == 4'd9)
      value_next = {value_reg[7:4] + 4'd1, 4'd0};
    else
      value_next = {value_reg[7:4], value_reg[3:0] + 4'd1};
  end

  always_ff @(posedge clk) begin
    if (reset)
      value_reg <= RESET_VAL;
    else if (load)
      value_reg <= load_val;
    else if (inc)
      value_reg <= at_max ? min_val : value_next;
  end

endmodule

// File: rtl/rtc_digit_bank.sv
// Live time/date/chrono registers with a field write port, plus a shadow copy
// refreshed only on the VGA vsync falling edge so the display never tears.
module rtc_digit_bank
  import rtc_pkg::*;
#(
  parameter logic [7:0] RESET_YEAR = 8'h16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_1hz_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_field_i,
  input  logic [7:0] wr_data_i,
  input  logic       chr_run_i,
  input  logic       chr_clr_i,
  input  logic       vsync_i,
  output logic       wr_err_o,
  output logic [3:0] dig_uh_o,
  output logic [3:0] dig_dh_o,
  output logic [3:0] dig_um_o,
  output logic [3:0] dig_dm_o,
  output logic [3:0] dig_us_o,
  output logic [3:0] dig_ds_o,
  output logic [3:0] dig_ud_o,
  output logic [3:0] dig_dd_o,
  output logic [3:0] dig_ume_o,
  output logic [3:0] dig_dme_o,
  output logic [3:0] dig_ua_o,
  output logic [3:0] dig_da_o,
  output logic [3:0] dig_uhc_o,
  output logic [3:0] dig_dhc_o,
  output logic [3:0] dig_umc_o,
  output logic [3:0] dig_dmc_o,
  output logic [3:0] dig_usc_o,
  output logic [3:0] dig_dsc_o
);

  localparam rtc_set_t RESET_SET = {BCD_00, BCD_00, BCD_00, BCD_01, BCD_01, RESET_YEAR,
                                    BCD_00, BCD_00, BCD_00};

  logic [7:0] sec, min, hour, day, month, year, csec, cmin, chour;
  logic       sec_carry, min_carry, hour_carry, day_carry, month_carry, year_carry;
  logic       csec_carry, cmin_carry, chour_carry;
  logic       unused_carry;

  logic       wr_valid, wr_ok, wr_rej;
  logic       wr_sec, wr_min, wr_hour, wr_day, wr_month, wr_year;
  logic [7:0] cur_len, new_month, new_year, new_len, day_load_val;
  logic       day_clamp, day_load;
  logic       tick_td, chr_tick;

  rtc_set_t   live;
  rtc_set_t   shadow_reg;
  logic       vs_q;
  logic       wr_err_reg;
  logic       frame_edge;

  always_comb begin
    cur_len  = month_len(month, year);
    wr_valid = 1'b0;
    case (rtc_field_e'(wr_field_i))
      FLD_SEC, FLD_MIN: wr_valid = (wr_data_i <= BCD_59);
      FLD_HOUR:         wr_valid = (wr_data_i <= BCD_23);
      FLD_DAY:          wr_valid = (wr_data_i != BCD_00) && (wr_data_i <= cur_len);
      FLD_MONTH:        wr_valid = (wr_data_i != BCD_00) && (wr_data_i <= BCD_12);
      FLD_YEAR:         wr_valid = 1'b1;
      default:          wr_valid = 1'b0;
    endcase
    if (wr_data_i[7:4] > 4'd9 || wr_data_i[3:0] > 4'd9)
      wr_valid = 1'b0;
  end

  assign wr_ok    = wr_en_i & wr_valid;
  assign wr_rej   = wr_en_i & ~wr_valid;
  assign wr_sec   = wr_ok & (wr_field_i == FLD_SEC);
  assign wr_min   = wr_ok & (wr_field_i == FLD_MIN);
  assign wr_hour  = wr_ok & (wr_field_i == FLD_HOUR);
  assign wr_day   = wr_ok & (wr_field_i == FLD_DAY);
  assign wr_month = wr_ok & (wr_field_i == FLD_MONTH);
  assign wr_year  = wr_ok & (wr_field_i == FLD_YEAR);

  // A month or year write can shorten the current month; pull the day back in the same cycle.
  assign new_month    = wr_month ? wr_data_i : month;
  assign new_year     = wr_year  ? wr_data_i : year;
  assign new_len      = month_len(new_month, new_year);
  assign day_clamp    = (wr_month | wr_year) & (day > new_len);
  assign day_load     = wr_day | day_clamp;
  assign day_load_val = wr_day ? wr_data_i : new_len;

  // Accepted writes swallow the time/date tick; the chrono is independent.
  assign tick_td  = tick_1hz_i & ~wr_ok;
  assign chr_tick = tick_1hz_i & chr_run_i;

  bcd2_counter #(.RESET_VAL(BCD_00)) u_sec (
    .clk(clk_i), .reset(reset_i), .inc(tick_td), .load(wr_sec), .load_val(wr_data_i),
    .max_val(BCD_59), .min_val(BCD_00), .value(sec), .carry(sec_carry));

  bcd2_counter #(.RESET_VAL(BCD_00)) u_min (
    .clk(clk_i), .reset(reset_i), .inc(sec_carry), .load(wr_min), .load_val(wr_data_i),
    .max_val(BCD_59), .min_val(BCD_00), .value(min), .carry(min_carry));

  bcd2_counter #(.RESET_VAL(BCD_00)) u_hour (
    .clk(clk_i), .reset(reset_i), .inc(min_carry), .load(wr_hour), .load_val(wr_data_i),
    .max_val(BCD_23), .min_val(BCD_00), .value(hour), .carry(hour_carry));

  bcd2_counter #(.RESET_VAL(BCD_01)) u_day (
    .clk(clk_i), .reset(reset_i), .inc(hour_carry), .load(day_load), .load_val(day_load_val),
    .max_val(cur_len), .min_val(BCD_01), .value(day), .carry(day_carry));

  bcd2_counter #(.RESET_VAL(BCD_01)) u_month (
    .clk(clk_i), .reset(reset_i), .inc(day_carry), .load(wr_month), .load_val(wr_data_i),
    .max_val(BCD_12), .min_val(BCD_01), .value(month), .carry(month_carry));

  bcd2_counter #(.RESET_VAL(RESET_YEAR)) u_year (
    .clk(clk_i), .reset(reset_i), .inc(month_carry), .load(wr_year), .load_val(wr_data_i),
    .max_val(BCD_99), .min_val(BCD_00), .value(year), .carry(year_carry));

  bcd2_counter #(.RESET_VAL(BCD_00)) u_csec (
    .clk(clk_i), .reset(reset_i), .inc(chr_tick), .load(chr_clr_i), .load_val(BCD_00),
    .max_val(BCD_59), .min_val(BCD_00), .value(csec), .carry(csec_carry));

  bcd2_counter #(.RESET_VAL(BCD_00)) u_cmin (
    .clk(clk_i), .reset(reset_i), .inc(csec_carry), .load(chr_clr_i), .load_val(BCD_00),
    .max_val(BCD_59), .min_val(BCD_00), .value(cmin), .carry(cmin_carry));

  bcd2_counter #(.RESET_VAL(BCD_00)) u_chour (
    .clk(clk_i), .reset(reset_i), .inc(cmin_carry), .load(chr_clr_i), .load_val(BCD_00),
    .max_val(BCD_99), .min_val(BCD_00), .value(chour), .carry(chour_carry));

  assign unused_carry = year_carry | chour_carry;

  assign live       = {hour, min, sec, day, month, year, chour, cmin, csec};
  assign frame_edge = vs_q & ~vsync_i;

  // Shadow samples the pre-update live set, so a same-cycle change shows one frame later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_reg <= RESET_SET;
      vs_q       <= 1'b1;
      wr_err_reg <= 1'b0;
    end else begin
      vs_q       <= vsync_i;
      wr_err_reg <= wr_rej;
      if (frame_edge)
        shadow_reg <= live;
    end
  end

  assign wr_err_o  = wr_err_reg;
  assign dig_uh_o  = shadow_reg.hour[3:0];
  assign dig_dh_o  = shadow_reg.hour[7:4];
  assign dig_um_o  = shadow_reg.min[3:0];
  assign dig_dm_o  = shadow_reg.min[7:4];
  assign dig_us_o  = shadow_reg.sec[3:0];
  assign dig_ds_o  = shadow_reg.sec[7:4];
  assign dig_ud_o  = shadow_reg.day[3:0];
  assign dig_dd_o  = shadow_reg.day[7:4];
  assign dig_ume_o = shadow_reg.month[3:0];
  assign dig_dme_o = shadow_reg.month[7:4];
  assign dig_ua_o  = shadow_reg.year[3:0];
  assign dig_da_o  = shadow_reg.year[7:4];
  assign dig_uhc_o = shadow_reg.chour[3:0];
  assign dig_dhc_o = shadow_reg.chour[7:4];
  assign dig_umc_o = shadow_reg.cmin[3:0];
  assign dig_dmc_o = shadow_reg.cmin[7:4];
  assign dig_usc_o = shadow_reg.csec[3:0];
  assign dig_dsc_o = shadow_reg.csec[7:4];

endmodule

// File: tb/tb_rtc_digit_bank.sv
// Scoreboard bench: stimulus queues expected display images and write errors;
// a monitor pops them whenever the DUT refreshes its outputs or pulses wr_err_o.
module tb_rtc_digit_bank;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_field = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       chr_run = 1'b0;
  logic       chr_clr = 1'b0;
  logic       vsync = 1'b1;

  logic       wr_err_o;
  logic [3:0] dig_uh_o, dig_dh_o, dig_um_o, dig_dm_o, dig_us_o, dig_ds_o;
  logic [3:0] dig_ud_o, dig_dd_o, dig_ume_o, dig_dme_o, dig_ua_o, dig_da_o;
  logic [3:0] dig_uhc_o, dig_dhc_o, dig_umc_o, dig_dmc_o, dig_usc_o, dig_dsc_o;

  always #5 clk = ~clk;

  rtc_digit_bank #(.RESET_YEAR(8'h16)) dut (
    .clk_i(clk), .reset_i(reset_i), .tick_1hz_i(tick),
    .wr_en_i(wr_en), .wr_field_i(wr_field), .wr_data_i(wr_data),
    .chr_run_i(chr_run), .chr_clr_i(chr_clr), .vsync_i(vsync), .wr_err_o(wr_err_o),
    .dig_uh_o(dig_uh_o), .dig_dh_o(dig_dh_o), .dig_um_o(dig_um_o), .dig_dm_o(dig_dm_o),
    .dig_us_o(dig_us_o), .dig_ds_o(dig_ds_o), .dig_ud_o(dig_ud_o), .dig_dd_o(dig_dd_o),
    .dig_ume_o(dig_ume_o), .dig_dme_o(dig_dme_o), .dig_ua_o(dig_ua_o), .dig_da_o(dig_da_o),
    .dig_uhc_o(dig_uhc_o), .dig_dhc_o(dig_dhc_o), .dig_umc_o(dig_umc_o), .dig_dmc_o(dig_dmc_o),
    .dig_usc_o(dig_usc_o), .dig_dsc_o(dig_dsc_o));

  // Display image as BCD bytes: hh mm ss dd mo yy chh cmm css.
  logic [71:0] disp;
  assign disp = {dig_dh_o, dig_uh_o, dig_dm_o, dig_um_o, dig_ds_o, dig_us_o,
                 dig_dd_o, dig_ud_o, dig_dme_o, dig_ume_o, dig_da_o, dig_ua_o,
                 dig_dhc_o, dig_uhc_o, dig_dmc_o, dig_umc_o, dig_dsc_o, dig_usc_o};

  typedef struct {
    string       name;
    logic [71:0] exp;
  } disp_exp_t;

  disp_exp_t disp_q[$];
  string     err_q[$];
  int        checks = 0;
  int        errors = 0;

  localparam logic [71:0] RST_IMG = 72'h000000_010116_000000;

  task automatic push_disp(input string name, input logic [71:0] exp);
    disp_exp_t e;
    e.name = name;
    e.exp  = exp;
    disp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] f, input logic [7:0] d, input logic tk);
    @(negedge clk);
    wr_en = 1'b1; wr_field = f; wr_data = d; tick = tk;
    @(negedge clk);
    wr_en = 1'b0; tick = 1'b0;
  endtask

  task automatic wr_bad(input string name, input logic [2:0] f, input logic [7:0] d);
    err_q.push_back(name);
    wr(f, d, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic frame(input string name, input logic [71:0] exp);
    push_disp(name, exp);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_with_tick(input string name, input logic [71:0] exp);
    push_disp(name, exp);
    @(negedge clk); vsync = 1'b0; tick = 1'b1;
    @(negedge clk); vsync = 1'b1; tick = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: reset or vsync falling edge refreshes outputs; otherwise they must hold.
  initial begin
    logic        vs_prev;
    logic        ev_rst, ev_edge;
    logic [71:0] last;
    disp_exp_t   item;
    string       ename;
    vs_prev = 1'b1;
    last = '0;
    forever begin
      @(posedge clk);
      ev_rst  = reset_i;
      ev_edge = vs_prev & ~vsync;
      vs_prev = ev_rst ? 1'b1 : vsync;
      #1;
      checks++;
      if (ev_rst || ev_edge) begin
        if (disp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_refresh actual %h required none", disp);
        end else begin
          item = disp_q.pop_front();
          if (disp !== item.exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", item.name, disp, item.exp);
          end else begin
            $display("refresh %s display %h", item.name, disp);
          end
        end
      end else if (disp !== last) begin
        errors++;
        $display("FAIL display_stable actual %h required %h", disp, last);
      end
      last = disp;
      if (wr_err_o !== 1'b0) begin
        checks++;
        if (wr_err_o !== 1'b1 || err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr_err actual %b required 0", wr_err_o);
        end else begin
          ename = err_q.pop_front();
          $display("wr_err %s pulsed", ename);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push_disp("reset", RST_IMG);
    @(negedge clk);
    reset_i = 1'b0;
    frame("reset_frame", RST_IMG);

    // 23:59:59 31/12/99 rolls over everything
    wr(3'd5, 8'h99, 1'b0); wr(3'd4, 8'h12, 1'b0); wr(3'd3, 8'h31, 1'b0);
    wr(3'd2, 8'h23, 1'b0); wr(3'd1, 8'h59, 1'b0); wr(3'd0, 8'h59, 1'b0);
    frame("preload", 72'h235959_311299_000000);
    ticks(1);
    frame("rollover", 72'h000000_010100_000000);

    // Leap year 16: 28/02 -> 29/02
    wr(3'd5, 8'h16, 1'b0); wr(3'd4, 8'h02, 1'b0); wr(3'd3, 8'h28, 1'b0);
    wr(3'd2, 8'h23, 1'b0); wr(3'd1, 8'h59, 1'b0); wr(3'd0, 8'h59, 1'b0);
    ticks(1);
    frame("leap16", 72'h000000_290216_000000);

    // Year 17 makes 29/02 invalid: day clamps to 28, then 28/02 -> 01/03
    wr(3'd5, 8'h17, 1'b0);
    frame("year_clamp", 72'h000000_280217_000000);
    wr(3'd2, 8'h23, 1'b0); wr(3'd1, 8'h59, 1'b0); wr(3'd0, 8'h59, 1'b0);
    ticks(1);
    frame("noleap17", 72'h000000_010317_000000);

    wr_bad("rej_sec_5A", 3'd0, 8'h5A);
    wr_bad("rej_hour_24", 3'd2, 8'h24);
    wr_bad("rej_field7", 3'd7, 8'h00);
    wr_bad("rej_day_32", 3'd3, 8'h32);
    wr_bad("rej_month_13", 3'd4, 8'h13);
    wr_bad("rej_day_00", 3'd3, 8'h00);
    frame("rej_unchanged", 72'h000000_010317_000000);

    // Write beats tick for time; running chrono still advances
    wr(3'd2, 8'h12, 1'b0); wr(3'd1, 8'h10, 1'b0); wr(3'd0, 8'h59, 1'b0);
    chr_run = 1'b1;
    wr(3'd1, 8'h30, 1'b1);
    chr_run = 1'b0;
    frame("wr_beats_tick", 72'h123059_010317_000001);

    ticks(3);
    repeat (5) @(negedge clk);
    frame("coherent", 72'h123102_010317_000001);
    frame_with_tick("edge_pre_update", 72'h123102_010317_000001);
    frame("edge_post_update", 72'h123103_010317_000001);

    chr_run = 1'b1;
    ticks(3);
    @(negedge clk); tick = 1'b1; chr_clr = 1'b1;
    @(negedge clk); tick = 1'b0; chr_clr = 1'b0;
    frame("chr_clear", 72'h123107_010317_000000);
    ticks(2);
    frame("chr_run2", 72'h123109_010317_000002);

    // Reset overrides a same-cycle tick, write and frame edge
    push_disp("reset_mid", RST_IMG);
    @(negedge clk);
    reset_i = 1'b1; tick = 1'b1; vsync = 1'b0; wr_en = 1'b1; wr_field = 3'd7;
    @(negedge clk);
    reset_i = 1'b0; tick = 1'b0; vsync = 1'b1; wr_en = 1'b0;
    chr_run = 1'b0;
    frame("post_reset", RST_IMG);

    wr(3'd3, 8'h31, 1'b0); wr(3'd4, 8'h04, 1'b0);
    frame("month_clamp", 72'h000000_300416_000000);
    wr(3'd4, 8'h02, 1'b0);
    frame("feb_clamp_leap", 72'h000000_290216_000000);

    repeat (4) @(negedge clk);
    foreach (disp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s actual no_refresh required %h", disp_q[i].name, disp_q[i].exp);
    end
    foreach (err_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s actual no_wr_err required pulse", err_q[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
